// File: rtl/u712_pkg.sv
// Shared definitions for the U712 chip RAM arbiter: state encoding, requester IDs, watchdog default.
package u712_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_PCI = 1'b1;

  localparam logic [7:0] DEF_TIMEOUT = 8'd64;

endpackage

// File: rtl/u712_arb_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting for MEM_ACK and flags TIMEOUT.
module u712_arb_watchdog
  import u712_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic CLK80,
  input  logic RESETn,
  input  logic run,
  output logic fire
);

  logic [7:0] cnt;

  // Counter is zero on the first WAIT cycle, so fire lands on WAIT cycle TIMEOUT.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign fire = run && (cnt == TIMEOUT - 8'd1);

endmodule

// File: rtl/u712_chip_arbiter.sv
// Chip RAM port arbiter between the 68040 CPU and the PCI bridge master.
// Optional WAIT watchdog with sticky ARB_ERR is compiled in with CHIP_ARB_WATCHDOG_EN.
module u712_chip_arbiter
  import u712_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic        CLK80,
  input  logic        RESETn,
  input  logic        CPU_REQ,
  input  logic        CPU_RnW,
  input  logic [18:0] CPU_A,
  input  logic        PCI_REQ,
  input  logic        PCI_RnW,
  input  logic [18:0] PCI_A,
  input  logic        DMA_BLOCK,
  input  logic        MEM_ACK,
  output logic        MEM_START,
  output logic        MEM_RnW,
  output logic [18:0] MEM_A,
  output logic        CPU_GNT,
  output logic        PCI_GNT,
  output logic        CPU_ACK,
  output logic        PCI_ACK,
  output logic        ARB_ERR,
  output logic [1:0]  DBG_STATE
);

  // Handshake: a requester raises REQ (level) with stable RnW/A and holds it until its
  // one-cycle ACK; it must drop REQ within two cycles of ACK or it is granted again.
  // MEM_START is a one-cycle pulse; MEM_RnW/MEM_A stay stable until the matching MEM_ACK.

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

  arb_state_e    state;
  logic          owner;
  logic [SW-1:0] streak;
  logic          pci_wins;
  logic          wd_fire;

  assign pci_wins  = PCI_REQ && (!CPU_REQ || (streak == STREAK_MAX));
  assign DBG_STATE = state;

`ifdef CHIP_ARB_WATCHDOG_EN
  u712_arb_watchdog u_watchdog (
    .CLK80  (CLK80),
    .RESETn (RESETn),
    .run    (state == ARB_WAIT),
    .fire   (wd_fire)
  );

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      ARB_ERR <= 1'b0;
    end else if (wd_fire) begin
      ARB_ERR <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign ARB_ERR = 1'b0;
`endif

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ARB_IDLE;
      owner     <= REQ_CPU;
      streak    <= '0;
      MEM_START <= 1'b0;
      MEM_RnW   <= 1'b1;
      MEM_A     <= '0;
      CPU_GNT   <= 1'b0;
      PCI_GNT   <= 1'b0;
      CPU_ACK   <= 1'b0;
      PCI_ACK   <= 1'b0;
    end else begin
      MEM_START <= 1'b0;
      CPU_ACK   <= 1'b0;
      PCI_ACK   <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (!DMA_BLOCK && (CPU_REQ || PCI_REQ)) begin
            state     <= ARB_ISSUE;
            MEM_START <= 1'b1;
            if (pci_wins) begin
              owner   <= REQ_PCI;
              PCI_GNT <= 1'b1;
              MEM_RnW <= PCI_RnW;
              MEM_A   <= PCI_A;
              streak  <= '0;
            end else begin
              owner   <= REQ_CPU;
              CPU_GNT <= 1'b1;
              MEM_RnW <= CPU_RnW;
              MEM_A   <= CPU_A;
              // Streak only builds while PCI is actually waiting behind the CPU.
              if (!PCI_REQ) begin
                streak <= '0;
              end else if (streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
              end
            end
          end
        end
        ARB_ISSUE, ARB_WAIT: begin
          if (MEM_ACK || wd_fire) begin
            state   <= ARB_DONE;
            CPU_ACK <= (owner == REQ_CPU);
            PCI_ACK <= (owner == REQ_PCI);
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_DONE: begin
          state   <= ARB_IDLE;
          CPU_GNT <= 1'b0;
          PCI_GNT <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u712_chip_arbiter.sv
// Self-checking bench for u712_chip_arbiter: directed scenarios plus random traffic against a reference model.
module tb_u712_chip_arbiter;

  localparam int M_MAX     = 4;
  localparam int M_TIMEOUT = 64;

  logic        CLK80, RESETn;
  logic        CPU_REQ, CPU_RnW, PCI_REQ, PCI_RnW, DMA_BLOCK, MEM_ACK;
  logic [18:0] CPU_A, PCI_A, MEM_A;
  logic        MEM_START, MEM_RnW, CPU_GNT, PCI_GNT, CPU_ACK, PCI_ACK, ARB_ERR;
  logic [1:0]  DBG_STATE;

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0=none 1=cpu 2=pci, age = cycles held, wcnt = cycles spent waiting
  int          m_owner  = 0;
  int          m_age    = 0;
  int          m_wcnt   = 0;
  int          m_streak = 0;
  bit          m_fin    = 0;
  bit          m_start  = 0;
  bit          m_cack   = 0;
  bit          m_pack   = 0;
  bit          m_err    = 0;
  logic [18:0] m_a      = '0;
  logic        m_rnw    = 1'b1;

  // Stimulus state
  int ack_tmr   = -1;
  int ack_delay = 8;
  bit ack_never = 0;
  bit ack_rand  = 0;
  bit spur      = 0;
  bit cpu_auto  = 0;
  bit pci_auto  = 0;
  int cpu_pct   = 100;
  int pci_pct   = 100;
  bit dma_rand  = 0;
  int n_start = 0, n_cpu_ack = 0, n_pci_ack = 0, n_pci_gnt = 0;
  int cyc_n = 0, t_start = 0, t_ack = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  u712_chip_arbiter dut (
    .CLK80     (CLK80),
    .RESETn    (RESETn),
    .CPU_REQ   (CPU_REQ),
    .CPU_RnW   (CPU_RnW),
    .CPU_A     (CPU_A),
    .PCI_REQ   (PCI_REQ),
    .PCI_RnW   (PCI_RnW),
    .PCI_A     (PCI_A),
    .DMA_BLOCK (DMA_BLOCK),
    .MEM_ACK   (MEM_ACK),
    .MEM_START (MEM_START),
    .MEM_RnW   (MEM_RnW),
    .MEM_A     (MEM_A),
    .CPU_GNT   (CPU_GNT),
    .PCI_GNT   (PCI_GNT),
    .CPU_ACK   (CPU_ACK),
    .PCI_ACK   (PCI_ACK),
    .ARB_ERR   (ARB_ERR),
    .DBG_STATE (DBG_STATE)
  );

  // Clock / reset: design acts on falling edges, bench drives and samples on rising edges.
  initial begin
    CLK80 = 1'b1;
    forever #5 CLK80 = ~CLK80;
  end

  always @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      m_owner = 0; m_age = 0; m_wcnt = 0; m_streak = 0; m_fin = 0;
      m_start = 0; m_cack = 0; m_pack = 0; m_err = 0; m_a = '0; m_rnw = 1'b1;
    end else begin
      m_start = 0; m_cack = 0; m_pack = 0;
      if (m_fin) begin
        m_fin   = 0;
        m_owner = 0;
      end else if (m_owner == 0) begin
        if (!DMA_BLOCK && (CPU_REQ || PCI_REQ)) begin
          if (PCI_REQ && (!CPU_REQ || m_streak == M_MAX)) begin
            m_owner = 2; m_a = PCI_A; m_rnw = PCI_RnW; m_streak = 0;
          end else begin
            m_owner = 1; m_a = CPU_A; m_rnw = CPU_RnW;
            m_streak = PCI_REQ ? ((m_streak < M_MAX) ? m_streak + 1 : M_MAX) : 0;
          end
          m_start = 1; m_age = 0; m_wcnt = 0;
        end
      end else begin
        bit done;
        done = MEM_ACK;
        if (m_age > 0) begin
          m_wcnt++;
`ifdef CHIP_ARB_WATCHDOG_EN
          if (m_wcnt == M_TIMEOUT) begin
            done  = 1;
            m_err = 1;
          end
`endif
        end
        m_age++;
        if (done) begin
          m_fin  = 1;
          m_cack = (m_owner == 1);
          m_pack = (m_owner == 2);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_start", 32'(MEM_START), 32'(m_start));
    chk("cpu_gnt",   32'(CPU_GNT),   32'(m_owner == 1));
    chk("pci_gnt",   32'(PCI_GNT),   32'(m_owner == 2));
    chk("cpu_ack",   32'(CPU_ACK),   32'(m_cack));
    chk("pci_ack",   32'(PCI_ACK),   32'(m_pack));
    chk("mem_a",     32'(MEM_A),     32'(m_a));
    chk("mem_rnw",   32'(MEM_RnW),   32'(m_rnw));
    chk("arb_err",   32'(ARB_ERR),   32'(m_err));
    chk("gnt_excl",  32'(CPU_GNT & PCI_GNT), 32'd0);
  endtask

  // Driver: one rising edge, check, then act as requesters and memory controller.
  task automatic cyc();
    @(posedge CLK80);
    cyc_n++;
    check_outputs();
    if (MEM_START) begin
      n_start++;
      t_start = cyc_n;
      got_q.push_back(CPU_GNT ? 2'd1 : 2'd2);
      ack_tmr = ack_never ? -1 : (ack_rand ? int'($urandom_range(0, 8)) : ack_delay);
    end
    if (PCI_GNT) n_pci_gnt++;
    if (CPU_ACK) begin n_cpu_ack++; t_ack = cyc_n; CPU_REQ = 1'b0; end
    if (PCI_ACK) begin n_pci_ack++; t_ack = cyc_n; PCI_REQ = 1'b0; end
    MEM_ACK = 1'b0;
    if (ack_tmr == 0) MEM_ACK = 1'b1;
    if (ack_tmr >= 0) ack_tmr--;
    if (spur) begin MEM_ACK = 1'b1; spur = 0; end
    if (cpu_auto && !CPU_REQ && !CPU_ACK && $urandom_range(0, 99) < cpu_pct) begin
      CPU_REQ = 1'b1; CPU_A = 19'($urandom); CPU_RnW = 1'($urandom);
    end
    if (pci_auto && !PCI_REQ && !PCI_ACK && $urandom_range(0, 99) < pci_pct) begin
      PCI_REQ = 1'b1; PCI_A = 19'($urandom); PCI_RnW = 1'($urandom);
    end
    if (dma_rand) DMA_BLOCK = ($urandom_range(0, 99) < 10);
  endtask

  task automatic wait_acks(input string tag, input int limit, input int cpu_tgt, input int pci_tgt);
    int k = 0;
    while ((n_cpu_ack < cpu_tgt || n_pci_ack < pci_tgt) && k < limit) begin
      cyc();
      k++;
    end
    chk({tag, "_ack_seen"}, 32'(n_cpu_ack >= cpu_tgt && n_pci_ack >= pci_tgt), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    cpu_auto = 0; pci_auto = 0; dma_rand = 0; DMA_BLOCK = 1'b0;
    while ((CPU_REQ || PCI_REQ) && k < 300) begin
      cyc();
      k++;
    end
    chk({tag, "_drained"}, 32'(CPU_REQ | PCI_REQ), 32'd0);
    repeat (3) cyc();
  endtask

  task automatic pulse_reset();
    @(posedge CLK80);
    #2 RESETn = 1'b0;
    ack_tmr = -1;
    MEM_ACK = 1'b0;
    #1;
    cyc();
    RESETn = 1'b1;
  endtask

  initial begin
    int k;
    RESETn = 1'b0; CPU_REQ = 1'b0; CPU_RnW = 1'b1; CPU_A = '0;
    PCI_REQ = 1'b0; PCI_RnW = 1'b1; PCI_A = '0; DMA_BLOCK = 1'b0; MEM_ACK = 1'b0;

    // Reset values
    repeat (3) cyc();
    chk("rst_rnw",   32'(MEM_RnW),   32'd1);
    chk("rst_a",     32'(MEM_A),     32'd0);
    chk("rst_state", 32'(DBG_STATE), 32'd0);
    chk("rst_err",   32'(ARB_ERR),   32'd0);
    RESETn = 1'b1;
    repeat (2) cyc();

    // Single CPU read, controller acks 8 cycles after start
    n_start = 0; n_pci_gnt = 0;
    CPU_REQ = 1'b1; CPU_A = 19'h01234; CPU_RnW = 1'b1; ack_delay = 8;
    wait_acks("t1", 40, 1, 0);
    repeat (3) cyc();
    chk("t1_starts",  32'(n_start),   32'd1);
    chk("t1_pci_gnt", 32'(n_pci_gnt), 32'd0);
    chk("t1_cpu_ack", 32'(n_cpu_ack), 32'd1);
    chk("t1_mem_a",   32'(MEM_A),     32'h01234);
    chk("t1_ack_lat", 32'(t_ack - t_start), 32'd9);

    // Both requesters saturated: four CPU grants then one PCI grant, repeating
    got_q.delete();
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    ack_delay = 1; cpu_pct = 100; pci_pct = 100;
    CPU_REQ = 1'b1; CPU_A = 19'h00100; PCI_REQ = 1'b1; PCI_A = 19'h7ff00; PCI_RnW = 1'b0;
    cpu_auto = 1; pci_auto = 1;
    k = 0;
    while (got_q.size() < exp_q.size() && k < 300) begin cyc(); k++; end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [1:0] g;
      g = (i < got_q.size()) ? got_q[i] : 2'd0;
      chk($sformatf("t2_grant%0d", i), 32'(g), 32'(exp_q[i]));
    end
    drain("t2");

    // DMA blackout holds off a grant; DMA rising mid-cycle does not abort it
    n_start = 0; ack_delay = 6;
    DMA_BLOCK = 1'b1; CPU_REQ = 1'b1; CPU_A = 19'h2aaaa; CPU_RnW = 1'b0;
    repeat (20) cyc();
    chk("t3_blocked", 32'(n_start), 32'd0);
    DMA_BLOCK = 1'b0;
    cyc();
    chk("t3_started", 32'(n_start), 32'd1);
    DMA_BLOCK = 1'b1;
    wait_acks("t3", 20, n_cpu_ack + 1, n_pci_ack);
    DMA_BLOCK = 1'b0;
    repeat (3) cyc();

    // Reset in WAIT aborts without ACK; held request re-arbitrated afterwards
    ack_never = 1;
    PCI_REQ = 1'b1; PCI_A = 19'h15555; PCI_RnW = 1'b1;
    k = 0;
    while (!PCI_GNT && k < 10) begin cyc(); k++; end
    repeat (3) cyc();
    @(posedge CLK80);
    #2 RESETn = 1'b0;
    ack_tmr = -1;
    #1;
    chk("t4_pci_gnt",   32'(PCI_GNT),   32'd0);
    chk("t4_pci_ack",   32'(PCI_ACK),   32'd0);
    chk("t4_mem_start", 32'(MEM_START), 32'd0);
    chk("t4_state",     32'(DBG_STATE), 32'd0);
    ack_never = 0; ack_delay = 3;
    cyc();
    RESETn = 1'b1;
    n_start = 0;
    wait_acks("t4", 30, n_cpu_ack, n_pci_ack + 1);
    chk("t4_restarts", 32'(n_start), 32'd1);
    repeat (3) cyc();

    // Controller never answers
    ack_never = 1;
    CPU_REQ = 1'b1; CPU_A = 19'h00abc;
`ifdef CHIP_ARB_WATCHDOG_EN
    wait_acks("t5_wd", 120, n_cpu_ack + 1, n_pci_ack);
    chk("t5_wd_len", 32'(t_ack - t_start), 32'(M_TIMEOUT + 1));
    repeat (5) cyc();
    chk("t5_err_held", 32'(ARB_ERR), 32'd1);
    pulse_reset();
    chk("t5_err_clr", 32'(ARB_ERR), 32'd0);
    ack_never = 0;
`else
    k = n_cpu_ack;
    repeat (100) cyc();
    chk("t5_no_ack",   32'(n_cpu_ack - k), 32'd0);
    chk("t5_gnt_held", 32'(CPU_GNT),       32'd1);
    chk("t5_err_zero", 32'(ARB_ERR),       32'd0);
    pulse_reset();
    ack_never = 0; ack_delay = 2;
    wait_acks("t5_recover", 20, k + 1, n_pci_ack);
`endif
    repeat (3) cyc();

    // MEM_ACK while idle with no request
    k = n_cpu_ack + n_pci_ack;
    n_start = 0;
    spur = 1;
    repeat (3) cyc();
    chk("t6_no_ack",   32'(n_cpu_ack + n_pci_ack - k), 32'd0);
    chk("t6_no_start", 32'(n_start),   32'd0);
    chk("t6_idle",     32'(DBG_STATE), 32'd0);

    // Random traffic
    ack_rand = 1; cpu_pct = 30; pci_pct = 30;
    cpu_auto = 1; pci_auto = 1; dma_rand = 1;
    repeat (800) cyc();
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
